// File: rtl/pcs_lane_emu_pkg.sv
// Shared constants, types and helpers for the PCS lane channel emulator.
//   PCS_HEAD_W / PCS_DATA_W / PCS_BLOCK_W : default 64b/66b block geometry
//   block_t                               : one full block, {data, head}
//   SYNC_DATA / SYNC_CTRL                 : legal sync header values
//   slip_st_e                             : per-lane slip request state
package pcs_lane_emu_pkg;

  localparam int unsigned PCS_HEAD_W  = 2;
  localparam int unsigned PCS_DATA_W  = 64;
  localparam int unsigned PCS_BLOCK_W = PCS_HEAD_W + PCS_DATA_W;

  typedef logic [PCS_BLOCK_W-1:0] block_t;

  localparam logic [PCS_HEAD_W-1:0] SYNC_DATA = 2'b01;
  localparam logic [PCS_HEAD_W-1:0] SYNC_CTRL = 2'b10;

  typedef enum logic {
    SlipIdle,
    SlipPend
  } slip_st_e;

  // Out-of-range skew requests saturate at the buffer limit.
  function automatic int unsigned clamp_skew(input int unsigned skew,
                                             input int unsigned max_skew);
    return (skew > max_skew) ? max_skew : skew;
  endfunction

  // Bit offsets are only meaningful modulo the block width.
  function automatic int unsigned wrap_shift(input int unsigned shift,
                                             input int unsigned block_w);
    return shift % block_w;
  endfunction

endpackage

// File: rtl/pcs_lane_emu_lane.sv
// One emulated lane: block delay line, two-block bit window and slip handling.
//   clk, reset        : clock, synchronous active-high reset
//   tx_v_i            : block valid; each valid advances the lane by one block
//   tx_head_i/data_i  : incoming block, wire order {data, head}, bit 0 first
//   cfg_skew_i        : delay in blocks (sampled while reset is high)
//   cfg_shift_i       : initial bit offset (sampled while reset is high)
//   gearbox_slip_i    : request to move the window by one bit
//   serdes_v_o        : registered output valid
//   serdes_head_o/data_o : realigned block
//   offset_o          : current window bit offset
module pcs_lane_emu_lane
  import pcs_lane_emu_pkg::*;
#(
  parameter int unsigned HEAD_W         = PCS_HEAD_W,
  parameter int unsigned DATA_W         = PCS_DATA_W,
  parameter int unsigned MAX_SKEW_BLK_N = 8,
  parameter int unsigned SHIFT_W        = 7,
  localparam int unsigned SKEW_W        = $clog2(MAX_SKEW_BLK_N + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_v_i,
  input  logic [HEAD_W-1:0]  tx_head_i,
  input  logic [DATA_W-1:0]  tx_data_i,
  input  logic [SKEW_W-1:0]  cfg_skew_i,
  input  logic [SHIFT_W-1:0] cfg_shift_i,
  input  logic               gearbox_slip_i,
  output logic               serdes_v_o,
  output logic [HEAD_W-1:0]  serdes_head_o,
  output logic [DATA_W-1:0]  serdes_data_o,
  output logic [SHIFT_W-1:0] offset_o
);

  localparam int unsigned BLOCK_W = HEAD_W + DATA_W;
  localparam int unsigned Depth   = MAX_SKEW_BLK_N + 1;
  localparam int unsigned PtrW    = $clog2(Depth);

  localparam logic [PtrW-1:0]    LastPtr = PtrW'(Depth - 1);
  localparam logic [SHIFT_W-1:0] LastOff = SHIFT_W'(BLOCK_W - 1);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  logic [SKEW_W-1:0]  skew_q;
  logic [SHIFT_W-1:0] off_q, off_d;
  logic [SKEW_W-1:0]  fill_q, fill_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [BLOCK_W-1:0] prev_q, prev_d;
  logic               primed_q, primed_d;
  slip_st_e           slip_st_q, slip_st_d;
  logic               v_q, v_d;
  logic [BLOCK_W-1:0] blk_q, blk_d;
  logic [BLOCK_W-1:0] mem_q [Depth];

  logic [BLOCK_W-1:0] blk_in;
  logic [BLOCK_W-1:0] cur;
  logic [BLOCK_W-1:0] out_blk;
  logic               bypass;
  logic               push;
  logic               pop;
  logic               apply_slip;

  // Delay line and window datapath.
  always_comb begin
    blk_in = {tx_data_i, tx_head_i};
    bypass = (skew_q == '0);
    // Once fill reaches skew every push is paired with a pop, so fill never exceeds skew.
    pop    = tx_v_i && (bypass || (fill_q >= skew_q));
    push   = tx_v_i && !bypass;
    cur    = bypass ? blk_in : mem_q[rd_ptr_q];
    // Window is {cur, prev}; offset 0 selects prev untouched.
    out_blk = BLOCK_W'({cur, prev_q} >> off_q);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (push && pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !pop) begin
      fill_d = fill_q + SKEW_W'(1);
    end

    prev_d   = prev_q;
    primed_d = primed_q;
    v_d      = 1'b0;
    blk_d    = blk_q;
    if (pop) begin
      prev_d   = cur;
      primed_d = 1'b1;
      // The first pop after reset only loads prev.
      if (primed_q) begin
        v_d   = 1'b1;
        blk_d = out_blk;
      end
    end
  end

  // Slip request FSM: one bit of offset per accepted slip, applied at a pop.
  always_comb begin
    slip_st_d  = slip_st_q;
    apply_slip = 1'b0;
    off_d      = off_q;
    case (slip_st_q)
      SlipIdle: begin
        if (gearbox_slip_i) begin
          if (pop) begin
            apply_slip = 1'b1;
          end else begin
            slip_st_d = SlipPend;
          end
        end
      end
      SlipPend: begin
        // Further slips while pending are dropped.
        if (pop) begin
          apply_slip = 1'b1;
          slip_st_d  = SlipIdle;
        end
      end
      default: slip_st_d = SlipIdle;
    endcase
    if (apply_slip) begin
      off_d = (off_q == LastOff) ? '0 : off_q + SHIFT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      skew_q    <= SKEW_W'(clamp_skew(32'(cfg_skew_i), MAX_SKEW_BLK_N));
      off_q     <= SHIFT_W'(wrap_shift(32'(cfg_shift_i), BLOCK_W));
      fill_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      prev_q    <= '0;
      primed_q  <= 1'b0;
      slip_st_q <= SlipIdle;
      v_q       <= 1'b0;
      blk_q     <= '0;
    end else begin
      off_q     <= off_d;
      fill_q    <= fill_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      prev_q    <= prev_d;
      primed_q  <= primed_d;
      slip_st_q <= slip_st_d;
      v_q       <= v_d;
      blk_q     <= blk_d;
    end
  end

  // Storage needs no reset: fill and pointers decide what is live.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= blk_in;
    end
  end

  assign serdes_v_o    = v_q;
  assign serdes_head_o = blk_q[HEAD_W-1:0];
  assign serdes_data_o = blk_q[BLOCK_W-1:HEAD_W];
  assign offset_o      = off_q;

endmodule

// File: rtl/pcs_lane_emu.sv
// Multi-lane channel emulator between pcs_tx gearbox outputs and pcs_rx serdes inputs.
// Adds per-lane block skew, bit misalignment and a gearbox_slip response so that block
// lock and deskew in pcs_rx get exercised. Bench / emulation use only.
//   clk, reset      : clock, synchronous active-high reset
//   tx_v_i/head_i/data_i          : per-lane blocks from pcs_tx (lane l at slice l)
//   cfg_skew_i / cfg_shift_i      : per-lane delay and initial bit offset, sampled in reset
//   gearbox_slip_i                : per-lane slip request from pcs_rx
//   serdes_v_o/head_o/data_o      : per-lane realigned blocks to pcs_rx
//   offset_o                      : per-lane current bit offset
module pcs_lane_emu
  import pcs_lane_emu_pkg::*;
#(
  parameter int unsigned LANE_N         = 4,
  parameter int unsigned HEAD_W         = PCS_HEAD_W,
  parameter int unsigned DATA_W         = PCS_DATA_W,
  parameter int unsigned MAX_SKEW_BLK_N = 8,
  parameter int unsigned SHIFT_W        = 7,
  localparam int unsigned SKEW_W        = $clog2(MAX_SKEW_BLK_N + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [LANE_N-1:0]         tx_v_i,
  input  logic [LANE_N*HEAD_W-1:0]  tx_head_i,
  input  logic [LANE_N*DATA_W-1:0]  tx_data_i,
  input  logic [LANE_N*SKEW_W-1:0]  cfg_skew_i,
  input  logic [LANE_N*SHIFT_W-1:0] cfg_shift_i,
  input  logic [LANE_N-1:0]         gearbox_slip_i,
  output logic [LANE_N-1:0]         serdes_v_o,
  output logic [LANE_N*HEAD_W-1:0]  serdes_head_o,
  output logic [LANE_N*DATA_W-1:0]  serdes_data_o,
  output logic [LANE_N*SHIFT_W-1:0] offset_o
);

  for (genvar l = 0; l < LANE_N; l++) begin : g_lane
    pcs_lane_emu_lane #(
      .HEAD_W         (HEAD_W),
      .DATA_W         (DATA_W),
      .MAX_SKEW_BLK_N (MAX_SKEW_BLK_N),
      .SHIFT_W        (SHIFT_W)
    ) u_lane (
      .clk            (clk),
      .reset          (reset),
      .tx_v_i         (tx_v_i[l]),
      .tx_head_i      (tx_head_i[l*HEAD_W +: HEAD_W]),
      .tx_data_i      (tx_data_i[l*DATA_W +: DATA_W]),
      .cfg_skew_i     (cfg_skew_i[l*SKEW_W +: SKEW_W]),
      .cfg_shift_i    (cfg_shift_i[l*SHIFT_W +: SHIFT_W]),
      .gearbox_slip_i (gearbox_slip_i[l]),
      .serdes_v_o     (serdes_v_o[l]),
      .serdes_head_o  (serdes_head_o[l*HEAD_W +: HEAD_W]),
      .serdes_data_o  (serdes_data_o[l*DATA_W +: DATA_W]),
      .offset_o       (offset_o[l*SHIFT_W +: SHIFT_W])
    );
  end

endmodule

// File: tb/tb_pcs_lane_emu.sv
module tb_pcs_lane_emu;

  localparam int LaneN  = 4;
  localparam int BlockW = 66;
  localparam int MaxSk  = 8;

  logic         clk;
  logic         rst;
  logic [3:0]   tx_v;
  logic [7:0]   tx_head;
  logic [255:0] tx_data;
  logic [15:0]  cfg_skew;
  logic [27:0]  cfg_shift;
  logic [3:0]   slip;
  logic [3:0]   sv;
  logic [7:0]   sh;
  logic [255:0] sd;
  logic [27:0]  soff;

  pcs_lane_emu #(
    .LANE_N         (4),
    .HEAD_W         (2),
    .DATA_W         (64),
    .MAX_SKEW_BLK_N (8),
    .SHIFT_W        (7)
  ) dut (
    .clk            (clk),
    .reset          (rst),
    .tx_v_i         (tx_v),
    .tx_head_i      (tx_head),
    .tx_data_i      (tx_data),
    .cfg_skew_i     (cfg_skew),
    .cfg_shift_i    (cfg_shift),
    .gearbox_slip_i (slip),
    .serdes_v_o     (sv),
    .serdes_head_o  (sh),
    .serdes_data_o  (sd),
    .offset_o       (soff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: each lane is a stream of blocks; the k-th valid since reset releases
  // block k-skew, and the output is the bit window starting 'off' bits into block p-1.
  logic [65:0] hist [LaneN][16];
  int          m_k   [LaneN];
  int          m_sk  [LaneN];
  int          m_off [LaneN];
  bit          m_pend[LaneN];
  bit   [3:0]  e_v;
  logic [65:0] e_blk [LaneN];

  bit head01   = 1'b0;
  bit idx_mode = 1'b0;
  int n_idx    = 0;

  task automatic model_step();
    for (int l = 0; l < LaneN; l++) begin
      if (rst) begin
        m_sk[l]   = int'(cfg_skew[l*4 +: 4]);
        if (m_sk[l] > MaxSk) m_sk[l] = MaxSk;
        m_off[l]  = int'(cfg_shift[l*7 +: 7]) % BlockW;
        m_k[l]    = 0;
        m_pend[l] = 1'b0;
        e_v[l]    = 1'b0;
        e_blk[l]  = '0;
      end else begin
        e_v[l] = 1'b0;
        if (slip[l]) m_pend[l] = 1'b1;
        if (tx_v[l]) begin
          int p;
          int used;
          logic [131:0] w;
          hist[l][m_k[l] % 16] = {tx_data[l*64 +: 64], tx_head[l*2 +: 2]};
          p = m_k[l] - m_sk[l];
          if (p >= 0) begin
            used = m_off[l];
            if (m_pend[l]) begin
              m_off[l]  = (m_off[l] + 1) % BlockW;
              m_pend[l] = 1'b0;
            end
            if (p >= 1) begin
              w = {hist[l][p % 16], hist[l][(p - 1) % 16]};
              w = w >> used;
              e_blk[l] = w[65:0];
              e_v[l]   = 1'b1;
            end
          end
          m_k[l]++;
        end
      end
    end
  endtask

  task automatic tick(input bit r, input logic [3:0] v, input logic [3:0] s);
    rst  = r;
    tx_v = v;
    slip = s;
    for (int l = 0; l < LaneN; l++) begin
      tx_head[l*2 +: 2]  = head01 ? 2'b01 : 2'($urandom);
      tx_data[l*64 +: 64] = idx_mode ? 64'(n_idx) : {$urandom, $urandom};
    end
    n_idx++;
    model_step();
    @(posedge clk);
    #1;
    for (int l = 0; l < LaneN; l++) begin
      check_eq($sformatf("v[%0d]", l), 64'(sv[l]), 64'(e_v[l]));
      check_eq($sformatf("head[%0d]", l), 64'(sh[l*2 +: 2]), 64'(e_blk[l][1:0]));
      check_eq($sformatf("data[%0d]", l), sd[l*64 +: 64], e_blk[l][65:2]);
      check_eq($sformatf("off[%0d]", l), 64'(soff[l*7 +: 7]), 64'(m_off[l]));
    end
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) tick(1'b1, 4'h0, 4'h0);
  endtask

  initial begin
    logic [63:0] first_data;
    rst = 1'b1; tx_v = '0; tx_head = '0; tx_data = '0; slip = '0;
    cfg_skew = '0; cfg_shift = '0;

    // 1: skew 0 / shift 0, output is input delayed by one block.
    do_reset(2);
    tick(1'b0, 4'hF, 4'h0);
    first_data = tx_data[63:0];
    check_eq("prime_v", 64'(sv[0]), 64'd0);
    tick(1'b0, 4'hF, 4'h0);
    check_eq("first_out", sd[63:0], first_data);
    for (int i = 0; i < 18; i++) tick(1'b0, 4'hF, 4'h0);

    // 2: skew {0,1,2,3}, lane x carries index n and emits n-x-1.
    cfg_skew = {4'd3, 4'd2, 4'd1, 4'd0};
    idx_mode = 1'b1; head01 = 1'b1;
    do_reset(1);
    n_idx = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 4'hF, 4'h0);
      for (int x = 0; x < LaneN; x++) begin
        if (sv[x]) check_eq($sformatf("idx[%0d]", x), sd[x*64 +: 64], 64'(n_idx - 1 - x - 1));
      end
    end
    idx_mode = 1'b0;

    // 3: shift 5 on lane 0, then 61 slips bring the window back to 0.
    cfg_skew = '0; cfg_shift = 28'd5;
    do_reset(1);
    for (int i = 0; i < 8; i++) tick(1'b0, 4'hF, 4'h0);
    for (int i = 0; i < 61; i++) tick(1'b0, 4'hF, 4'h1);
    check_eq("slip61_off", 64'(soff[6:0]), 64'd0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 4'hF, 4'h0);
      check_eq("aligned_head", 64'(sh[1:0]), 64'd1);
    end
    head01 = 1'b0;

    // 4: wrap from 65 and dropped second slip.
    cfg_shift = 28'd65;
    do_reset(1);
    tick(1'b0, 4'h0, 4'h1);
    tick(1'b0, 4'hF, 4'h0);
    check_eq("wrap_off", 64'(soff[6:0]), 64'd0);
    tick(1'b0, 4'h0, 4'h1);
    tick(1'b0, 4'h0, 4'h1);
    tick(1'b0, 4'hF, 4'h0);
    check_eq("double_slip_off", 64'(soff[6:0]), 64'd1);

    // 5: skew 2, valid one cycle in three.
    cfg_skew = {4'd2, 4'd2, 4'd2, 4'd2}; cfg_shift = 28'($urandom);
    do_reset(1);
    for (int i = 0; i < 36; i++) tick(1'b0, (i % 3 == 0) ? 4'hF : 4'h0, 4'h0);

    // 6: mid-stream reset with skew 4, silent for 5 valids.
    cfg_skew = '0; cfg_shift = '0;
    do_reset(1);
    for (int i = 0; i < 6; i++) tick(1'b0, 4'hF, 4'h0);
    cfg_skew = {4'd4, 4'd4, 4'd4, 4'd4};
    tick(1'b1, 4'hF, 4'h0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 4'hF, 4'h0);
      check_eq("post_rst_quiet", 64'(sv), 64'd0);
    end
    tick(1'b0, 4'hF, 4'h0);
    check_eq("post_rst_resume", 64'(sv), 64'hF);

    // Random traffic, config (including out-of-range values) and mid-stream resets.
    for (int seg = 0; seg < 30; seg++) begin
      cfg_skew  = 16'($urandom);
      cfg_shift = 28'($urandom);
      do_reset(1 + int'($urandom_range(1)));
      for (int i = 0; i < 60; i++) begin
        logic [3:0] v;
        logic [3:0] s;
        for (int l = 0; l < LaneN; l++) begin
          v[l] = ($urandom_range(2) != 0);
          s[l] = ($urandom_range(7) == 0);
        end
        if ($urandom_range(99) == 0) begin
          cfg_skew  = 16'($urandom);
          cfg_shift = 28'($urandom);
          tick(1'b1, v, s);
        end else begin
          tick(1'b0, v, s);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
